// File: rtl/reg_bank_seq_if.sv
// Bus bundle between the decoder/control unit and the register bank.
// Carries the three read ports, the write port, the PC/link strobes and the
// load/store-multiple sequencer handshake.
//   slave  : the register bank side (reg_bank_seq)
//   master : the control unit side
interface reg_bank_seq_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  logic [ADDR_W-1:0]   ra_addr;
  logic [ADDR_W-1:0]   rb_addr;
  logic [ADDR_W-1:0]   rc_addr;
  logic [DATA_W-1:0]   ra_data;
  logic [DATA_W-1:0]   rb_data;
  logic [DATA_W-1:0]   rc_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                pc_inc;
  logic                link;
  logic [DATA_W-1:0]   pc_out;
  logic                lsm_start;
  logic [NUM_REGS-1:0] lsm_list;
  logic                lsm_desc;
  logic                lsm_valid;
  logic [ADDR_W-1:0]   lsm_reg;
  logic                lsm_ack;
  logic [ADDR_W:0]     lsm_count;
  logic                lsm_busy;
  logic                lsm_done;

  modport slave (
    input  ra_addr, rb_addr, rc_addr, wr_en, wr_addr, wr_data, pc_inc, link,
           lsm_start, lsm_list, lsm_desc, lsm_ack,
    output ra_data, rb_data, rc_data, pc_out,
           lsm_valid, lsm_reg, lsm_count, lsm_busy, lsm_done
  );

  modport master (
    output ra_addr, rb_addr, rc_addr, wr_en, wr_addr, wr_data, pc_inc, link,
           lsm_start, lsm_list, lsm_desc, lsm_ack,
    input  ra_data, rb_data, rc_data, pc_out,
           lsm_valid, lsm_reg, lsm_count, lsm_busy, lsm_done
  );
endinterface

// File: rtl/reg_bank_seq.sv
// Register bank: NUM_REGS x DATA_W register file with three combinational
// read ports (write-through forwarding from the write port), one write port,
// a PC incrementer with link write, and a load/store-multiple sequencer that
// hands out one register index per acknowledged beat.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (also aborts a running sequence)
//   bus : reg_bank_seq_if.slave -- read/write ports, pc_inc/link, pc_out,
//         and the lsm_* sequencer handshake
module reg_bank_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int PC_IDX   = 15,
  parameter int LR_IDX   = 14,
  parameter int PC_INC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  reg_bank_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   w_pc_plus;

  state_t              r_state, w_state_next;
  logic [NUM_REGS-1:0] r_list, w_list_next;
  logic                r_desc, w_desc_next;
  logic [ADDR_W:0]     r_count, w_count_next;
  logic [ADDR_W:0]     w_pop;
  logic [ADDR_W-1:0]   w_sel;
  logic [NUM_REGS-1:0] w_rest;

  logic [ADDR_W-1:0]   w_raddr [3];
  logic [DATA_W-1:0]   w_rdata [3];

  // ---------------- register file ----------------
  assign w_pc_plus = r_regs[PC_IDX] + DATA_W'(PC_INC);

  // Later non-blocking assignments win, so an explicit write overrides the
  // PC increment / link update to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (bus.link)   r_regs[LR_IDX]      <= w_pc_plus;
      if (bus.pc_inc) r_regs[PC_IDX]      <= w_pc_plus;
      if (bus.wr_en)  r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign w_raddr[0] = bus.ra_addr;
  assign w_raddr[1] = bus.rb_addr;
  assign w_raddr[2] = bus.rc_addr;

  // Forwarding covers only the explicit write port; pc_inc/link results
  // appear the cycle after.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      assign w_rdata[gi] = (bus.wr_en && (bus.wr_addr == w_raddr[gi]))
                           ? bus.wr_data : r_regs[w_raddr[gi]];
    end
  endgenerate

  assign bus.ra_data = w_rdata[0];
  assign bus.rb_data = w_rdata[1];
  assign bus.rc_data = w_rdata[2];
  assign bus.pc_out  = r_regs[PC_IDX];

  // ---------------- LSM sequencer ----------------
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_REGS; i++) w_pop = w_pop + (ADDR_W+1)'(bus.lsm_list[i]);
  end

  // Priority pick from the remaining list; the last match in the scan wins,
  // so scan from the end opposite to the wanted one.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_desc) begin
        if (r_list[i]) w_sel = ADDR_W'(i);
      end else begin
        if (r_list[NUM_REGS-1-i]) w_sel = ADDR_W'(NUM_REGS-1-i);
      end
    end
  end

  assign w_rest = r_list & ~(NUM_REGS'(1) << w_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_list  <= '0;
      r_desc  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_list  <= w_list_next;
      r_desc  <= w_desc_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_list_next  = r_list;
    w_desc_next  = r_desc;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.lsm_start) begin
          w_list_next  = bus.lsm_list;
          w_desc_next  = bus.lsm_desc;
          w_count_next = w_pop;
          w_state_next = (bus.lsm_list != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (bus.lsm_ack) begin
          w_list_next = w_rest;
          if (w_rest == '0) w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.lsm_valid = (r_state == S_RUN);
  assign bus.lsm_busy  = (r_state != S_IDLE);
  assign bus.lsm_done  = (r_state == S_DONE);
  assign bus.lsm_reg   = w_sel;
  assign bus.lsm_count = r_count;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Testbench for reg_bank_seq: directed stimulus with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.
module tb_reg_bank_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_bank_seq_if bus ();

  reg_bank_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [16];
  int          m_q[$];
  int          m_phase = 0;   // 0 idle, 1 run, 2 done
  int          m_count = 0;
  bit          m_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input bit loud);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else if (loud) begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic model_step();
    logic [31:0] pc_old;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_q.delete();
      m_phase = 0;
      m_count = 0;
      m_en    = 1'b1;
    end else begin
      pc_old = m_regs[15];
      if (bus.link)   m_regs[14] = pc_old + 32'd4;
      if (bus.pc_inc) m_regs[15] = pc_old + 32'd4;
      if (bus.wr_en)  m_regs[bus.wr_addr] = bus.wr_data;
      case (m_phase)
        0: if (bus.lsm_start) begin
             m_q.delete();
             for (int i = 0; i < 16; i++) begin
               int idx;
               idx = bus.lsm_desc ? 15 - i : i;
               if (bus.lsm_list[idx]) m_q.push_back(idx);
             end
             m_count = m_q.size();
             m_phase = (m_q.size() != 0) ? 1 : 2;
           end
        1: if (bus.lsm_ack) begin
             void'(m_q.pop_front());
             if (m_q.size() == 0) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    return (bus.wr_en && bus.wr_addr == a) ? bus.wr_data : m_regs[a];
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_en) begin
      chk("m_ra", bus.ra_data, m_read(bus.ra_addr), 1'b0);
      chk("m_rb", bus.rb_data, m_read(bus.rb_addr), 1'b0);
      chk("m_rc", bus.rc_data, m_read(bus.rc_addr), 1'b0);
      chk("m_pc", bus.pc_out, m_regs[15], 1'b0);
      chk("m_valid", 32'(bus.lsm_valid), 32'(m_phase == 1), 1'b0);
      chk("m_busy", 32'(bus.lsm_busy), 32'(m_phase != 0), 1'b0);
      chk("m_done", 32'(bus.lsm_done), 32'(m_phase == 2), 1'b0);
      chk("m_count", 32'(bus.lsm_count), 32'(m_count), 1'b0);
      if (m_phase == 1) chk("m_reg", 32'(bus.lsm_reg), 32'(m_q[0]), 1'b0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ra_addr = '0; bus.rb_addr = '0; bus.rc_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.pc_inc = 1'b0; bus.link = 1'b0;
    bus.lsm_start = 1'b0; bus.lsm_list = '0; bus.lsm_desc = 1'b0; bus.lsm_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset clears a written register
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'hDEAD;
    tick();
    bus.wr_en = 1'b0; bus.ra_addr = 4'd3; rst = 1'b1;
    @(negedge clk); chk("r3_before_rst", bus.ra_data, 32'hDEAD, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ra", bus.ra_data, 32'h0, 1'b1);
    chk("rst_pc", bus.pc_out, 32'h0, 1'b1);
    chk("rst_busy", 32'(bus.lsm_busy), 32'h0, 1'b1);

    // Same-cycle forwarding, then stored value
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h1234; bus.ra_addr = 4'd5;
    bus.rc_addr = 4'd3;
    @(negedge clk); chk("fwd_ra", bus.ra_data, 32'h1234, 1'b1);
    tick();
    bus.wr_en = 1'b0;
    @(negedge clk); chk("r5_stored", bus.ra_data, 32'h1234, 1'b1);

    // PC / link
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 32'h100;
    tick();
    bus.wr_en = 1'b0; bus.pc_inc = 1'b1; bus.link = 1'b1; bus.rb_addr = 4'd14;
    @(negedge clk); chk("pc_0x100", bus.pc_out, 32'h100, 1'b1);
    tick();
    bus.pc_inc = 1'b0; bus.link = 1'b0;
    @(negedge clk);
    chk("pc_after_inc", bus.pc_out, 32'h104, 1'b1);
    chk("lr_after_link", bus.rb_data, 32'h104, 1'b1);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 32'h200; bus.pc_inc = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.ra_addr = 4'd15;
    @(negedge clk);
    chk("pc_wr_wins", bus.pc_out, 32'h200, 1'b1);
    chk("no_fwd_pcinc", bus.ra_data, 32'h200, 1'b1);
    tick();
    bus.pc_inc = 1'b0;
    @(negedge clk); chk("pc_204", bus.ra_data, 32'h204, 1'b1);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd15; bus.wr_data = 32'hFFFF_FFFC;
    tick();
    bus.wr_en = 1'b0; bus.pc_inc = 1'b1;
    tick();
    bus.pc_inc = 1'b0;
    @(negedge clk); chk("pc_wrap", bus.pc_out, 32'h0, 1'b1);
    tick();
    bus.link = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd14; bus.wr_data = 32'hABC;
    tick();
    bus.link = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk); chk("lr_wr_wins", bus.rb_data, 32'hABC, 1'b1);

    // LSM ascending, ack every cycle
    tick();
    bus.lsm_list = 16'h8011; bus.lsm_desc = 1'b0; bus.lsm_ack = 1'b1; bus.lsm_start = 1'b1;
    tick();
    bus.lsm_start = 1'b0;
    @(negedge clk);
    chk("asc_reg0", 32'(bus.lsm_reg), 32'd0, 1'b1);
    chk("asc_count", 32'(bus.lsm_count), 32'd3, 1'b1);
    tick(); @(negedge clk); chk("asc_reg4", 32'(bus.lsm_reg), 32'd4, 1'b1);
    tick(); @(negedge clk); chk("asc_reg15", 32'(bus.lsm_reg), 32'd15, 1'b1);
    tick(); @(negedge clk); chk("asc_done", 32'(bus.lsm_done), 32'd1, 1'b1);
    tick(); @(negedge clk); chk("asc_busy_off", 32'(bus.lsm_busy), 32'd0, 1'b1);
    tick();
    bus.lsm_ack = 1'b0;

    // LSM descending with stall; start during RUN ignored
    bus.lsm_list = 16'h0006; bus.lsm_desc = 1'b1; bus.lsm_start = 1'b1;
    tick();
    bus.lsm_list = 16'hFFFF;
    @(negedge clk); chk("desc_reg2", 32'(bus.lsm_reg), 32'd2, 1'b1);
    tick();
    bus.lsm_start = 1'b0;
    @(negedge clk); chk("desc_reg2_held", 32'(bus.lsm_reg), 32'd2, 1'b1);
    tick();
    bus.lsm_ack = 1'b1;
    @(negedge clk); chk("desc_count", 32'(bus.lsm_count), 32'd2, 1'b1);
    tick(); @(negedge clk); chk("desc_reg1", 32'(bus.lsm_reg), 32'd1, 1'b1);
    tick();
    bus.lsm_ack = 1'b0;
    @(negedge clk); chk("desc_done", 32'(bus.lsm_done), 32'd1, 1'b1);

    // Empty list, then back-to-back start in the cycle after DONE
    tick();
    bus.lsm_list = 16'h0000; bus.lsm_desc = 1'b0; bus.lsm_start = 1'b1;
    tick();
    bus.lsm_list = 16'h0002;
    @(negedge clk);
    chk("empty_done", 32'(bus.lsm_done), 32'd1, 1'b1);
    chk("empty_count", 32'(bus.lsm_count), 32'd0, 1'b1);
    tick();
    @(negedge clk); chk("empty_idle", 32'(bus.lsm_busy), 32'd0, 1'b1);
    tick();
    bus.lsm_start = 1'b0;
    @(negedge clk); chk("b2b_reg1", 32'(bus.lsm_reg), 32'd1, 1'b1);
    tick();
    bus.lsm_ack = 1'b1;
    tick();
    bus.lsm_ack = 1'b0;
    tick();

    // Abort mid-RUN by reset
    bus.lsm_list = 16'h00F0; bus.lsm_start = 1'b1;
    tick();
    bus.lsm_start = 1'b0;
    @(negedge clk); chk("abort_reg4", 32'(bus.lsm_reg), 32'd4, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.lsm_busy), 32'd0, 1'b1);
    chk("abort_count", 32'(bus.lsm_count), 32'd0, 1'b1);
    chk("abort_lr_clr", bus.rb_data, 32'h0, 1'b1);
    tick();
    @(negedge clk); chk("abort_no_done", 32'(bus.lsm_done), 32'd0, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
